// File: rtl/sound_pkg.sv
// Shared encodings for the sound sequencer: FSM states, melody ids and the
// half-period table (clk cycles per half square-wave period, 0 = rest).
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] ID_P2   = 2'd0;
  localparam logic [1:0] ID_P1   = 2'd1;
  localparam logic [1:0] ID_LOSE = 2'd2;
  localparam logic [1:0] ID_WIN  = 2'd3;

  function automatic logic [14:0] half_lookup(input logic [1:0] id, input logic [1:0] idx);
    logic [14:0] h;
    h = 15'd0;
    case (id)
      ID_WIN: begin
        case (idx)
          2'd0:    h = 15'd11364;
          2'd1:    h = 15'd9019;
          2'd2:    h = 15'd7584;
          default: h = 15'd5682;
        endcase
      end
      ID_LOSE: begin
        case (idx)
          2'd0:    h = 15'd7584;
          2'd1:    h = 15'd9019;
          2'd2:    h = 15'd11364;
          default: h = 15'd15169;
        endcase
      end
      ID_P1:   h = (idx == 2'd0) ? 15'd5682 : 15'd0;
      default: h = (idx == 2'd0) ? 15'd7584 : 15'd0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave generator: a half-period down-counter plus the toggle flop.
// start restarts the wave high (or holds it low for a rest).
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] half,
  output logic        tone_out
);

  logic [14:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 15'd0;
      tone_out <= 1'b0;
    end else if (start) begin
      cnt      <= (half == 15'd0) ? 15'd0 : half - 15'd1;
      tone_out <= (half != 15'd0);
    end else if (half != 15'd0) begin
      if (cnt == 15'd0) begin
        cnt      <= half - 15'd1;
        tone_out <= ~tone_out;
      end else begin
        cnt <= cnt - 15'd1;
      end
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Melody sequencer: latches request pulses into a pending register, plays the
// highest-priority melody note by note, and lets higher priorities preempt.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int NOTE_CYC = 1250000,
  parameter int GAP_CYC  = 125000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_win,
  input  logic       req_lose,
  input  logic       req_p1,
  input  logic       req_p2,
  input  logic       mute,
  output logic       spk,
  output logic       busy,
  output logic [1:0] cur_id,
  output logic       done
);

  localparam logic [23:0] NOTE_LOAD = 24'(NOTE_CYC - 1);
  localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYC - 1);

  state_t      state;
  logic [3:0]  pend;
  logic [1:0]  note_idx;
  logic [23:0] timer;

  logic [3:0]  req_vec;
  logic [3:0]  req_eff;
  logic [3:0]  higher_mask;
  logic [3:0]  clr_mask;
  logic [1:0]  sel_id;
  logic [1:0]  half_idx;
  logic [14:0] half;
  logic        any_pend;
  logic        preempt;
  logic        play_end;
  logic        go_load;
  logic        tone_start;
  logic        tone_out;

  // Requests are single-cycle pulses, bit index = melody id; done is a
  // single-cycle pulse on the edge that retires the last note of a melody.
  always_comb begin
    req_vec = {req_win, req_lose, req_p1, req_p2};
    req_eff = req_vec;
    if (state != ST_IDLE) begin
      req_eff[cur_id] = 1'b0;
      if (cur_id[1]) req_eff[1:0] = 2'b00;
    end

    any_pend = |pend;
    if (pend[3])      sel_id = ID_WIN;
    else if (pend[2]) sel_id = ID_LOSE;
    else if (pend[1]) sel_id = ID_P1;
    else              sel_id = ID_P2;

    case (cur_id)
      ID_WIN:  higher_mask = 4'b0000;
      ID_LOSE: higher_mask = 4'b1000;
      ID_P1:   higher_mask = 4'b1100;
      default: higher_mask = 4'b1110;
    endcase
    preempt = ((state == ST_PLAY) || (state == ST_GAP)) && (|(pend & higher_mask));

    play_end = (state == ST_PLAY) && (timer == 24'd0) && !preempt;
    go_load  = ((state == ST_IDLE) && any_pend) || preempt ||
               (play_end && (note_idx == 2'd3) && any_pend);

    clr_mask = 4'b0000;
    if (go_load) begin
      clr_mask[sel_id] = 1'b1;
      if (sel_id[1]) clr_mask[1:0] = 2'b11;
    end

    // The tone restarts on the edge that enters PLAY, so look up the next note.
    half_idx   = (state == ST_GAP) ? note_idx + 2'd1 : note_idx;
    half       = half_lookup(cur_id, half_idx);
    tone_start = (state == ST_LOAD) ||
                 ((state == ST_GAP) && (timer == 24'd0) && !preempt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pend     <= 4'b0000;
      note_idx <= 2'd0;
      timer    <= 24'd0;
      cur_id   <= 2'd0;
      done     <= 1'b0;
    end else begin
      pend <= (pend | req_eff) & ~clr_mask;
      done <= play_end && (note_idx == 2'd3);
      if (go_load) begin
        state    <= ST_LOAD;
        cur_id   <= sel_id;
        note_idx <= 2'd0;
      end else begin
        case (state)
          ST_LOAD: begin
            state <= ST_PLAY;
            timer <= NOTE_LOAD;
          end
          ST_PLAY: begin
            if (timer == 24'd0) begin
              if (note_idx == 2'd3) begin
                state  <= ST_IDLE;
                cur_id <= 2'd0;
              end else begin
                state <= ST_GAP;
                timer <= GAP_LOAD;
              end
            end else begin
              timer <= timer - 24'd1;
            end
          end
          ST_GAP: begin
            if (timer == 24'd0) begin
              state    <= ST_PLAY;
              timer    <= NOTE_LOAD;
              note_idx <= note_idx + 2'd1;
            end else begin
              timer <= timer - 24'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  tone_gen u_tone_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (tone_start),
    .half     (half),
    .tone_out (tone_out)
  );

  assign busy = (state != ST_IDLE);
  assign spk  = tone_out & ~mute & (state == ST_PLAY);

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with NOTE_CYC=20, GAP_CYC=4. Each
// completion is scoreboarded as {id, done cycle, speaker-high cycle count}.
module tb_sound_sequencer;

  localparam int W = 26;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_win, req_lose, req_p1, req_p2;
  logic       mute;
  logic       spk, busy, done;
  logic [1:0] cur_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  sound_sequencer #(.NOTE_CYC(20), .GAP_CYC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_win  (req_win),
    .req_lose (req_lose),
    .req_p1   (req_p1),
    .req_p2   (req_p2),
    .mute     (mute),
    .spk      (spk),
    .busy     (busy),
    .cur_id   (cur_id),
    .done     (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called #1 after a posedge; the pulse is sampled at the next edge, whose
  // cycle number is returned.
  task automatic pulse(input logic [3:0] m, output int n);
    {req_win, req_lose, req_p1, req_p2} = m;
    @(posedge clk);
    #1;
    n = cyc;
    {req_win, req_lose, req_p1, req_p2} = 4'b0000;
  endtask

  task automatic at_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic expect_done(input logic [1:0] id, input int c, input int hi);
    exp_q.push_back({id, c[15:0], hi[7:0]});
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [1:0]   last_id = 2'd0;
  int           hi_cnt  = 0;
  logic [W-1:0] got_rec, exp_rec;

  always @(negedge clk) begin
    if (spk === 1'b1) hi_cnt++;
    if (done === 1'b1) begin
      got_rec = {last_id, cyc[15:0], hi_cnt[7:0]};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got id %0d cyc %0d hi %0d, required no done",
                 last_id, cyc, hi_cnt);
      end else begin
        exp_rec = exp_q.pop_front();
        if (got_rec !== exp_rec) begin
          errors++;
          $display("FAIL done_record: got id %0d cyc %0d hi %0d, required id %0d cyc %0d hi %0d",
                   got_rec[25:24], got_rec[23:8], got_rec[7:0],
                   exp_rec[25:24], exp_rec[23:8], exp_rec[7:0]);
        end
      end
    end
    if (busy !== 1'b1 || cur_id !== last_id) hi_cnt = 0;
    last_id = cur_id;
  end

  // ---------------- stimulus ----------------
  int n, m;

  initial begin
    rst = 1'b1;
    {req_win, req_lose, req_p1, req_p2} = 4'b0000;
    mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spk", spk, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_id", cur_id, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single p1 chirp
    pulse(4'b0010, n);
    expect_done(2'd1, n + 94, 20);
    at_cyc(n + 1);
    check("p1_load_busy", busy, 1);
    check("p1_load_id", cur_id, 1);
    check("p1_load_spk", spk, 0);
    at_cyc(n + 2);
    check("p1_play_spk", spk, 1);
    at_cyc(n + 21);
    check("p1_note_end_spk", spk, 1);
    at_cyc(n + 22);
    check("p1_gap_spk", spk, 0);
    at_cyc(n + 26);
    check("p1_rest_spk", spk, 0);
    check("p1_rest_busy", busy, 1);
    at_cyc(n + 95);
    check("p1_idle_busy", busy, 0);
    at_cyc(n + 100);

    // win and p2 together: win plays, p2 discarded
    pulse(4'b1001, n);
    expect_done(2'd3, n + 94, 80);
    at_cyc(n + 1);
    check("win_p2_id", cur_id, 3);
    at_cyc(n + 95);
    check("win_p2_busy_after", busy, 0);
    at_cyc(n + 100);
    check("win_p2_no_replay", busy, 0);

    // lose preempts p2 during note 1
    pulse(4'b0001, n);
    at_cyc(n + 29);
    pulse(4'b0100, m);
    expect_done(2'd2, m + 94, 80);
    at_cyc(m + 1);
    check("preempt_id", cur_id, 2);
    check("preempt_busy", busy, 1);
    at_cyc(m + 100);

    // p2 and repeated win during win playback are dropped
    pulse(4'b1000, n);
    expect_done(2'd3, n + 94, 80);
    at_cyc(n + 10);
    pulse(4'b0001, m);
    at_cyc(n + 40);
    pulse(4'b1000, m);
    at_cyc(n + 100);
    check("win_drop_idle", busy, 0);
    check("win_drop_id", cur_id, 0);

    // muted lose: same timing, speaker never high
    mute = 1'b1;
    pulse(4'b0100, n);
    expect_done(2'd2, n + 94, 0);
    at_cyc(n + 50);
    check("mute_busy", busy, 1);
    check("mute_id", cur_id, 2);
    at_cyc(n + 95);
    mute = 1'b0;
    at_cyc(n + 100);

    // reset mid-PLAY of win with a lose request pending
    pulse(4'b1000, n);
    at_cyc(n + 29);
    check("prerst_spk", spk, 1);
    pulse(4'b0100, m);
    rst = 1'b1;
    #1;
    check("midrst_spk", spk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_id", cur_id, 0);
    check("midrst_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    at_cyc(cyc + 6);
    check("postrst_no_pending", busy, 0);
    pulse(4'b0010, n);
    expect_done(2'd1, n + 94, 20);
    at_cyc(n + 2);
    check("postrst_p1_id", cur_id, 1);
    check("postrst_p1_spk", spk, 1);
    at_cyc(n + 100);

    check("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 The block SHALL have parameter NOTE_CYC, default 1250000, meaning clk cycles per note (125 ms at 10 MHz).
REQ-002 The block SHALL have parameter GAP_CYC, default 125000, meaning silent clk cycles between notes.
REQ-003 Port clk, input, 1, system clock (10 MHz).
REQ-004 Port rst, input, 1, reset, asynchronous, active-high.
REQ-005 Port req_win, input, 1, one-cycle pulse requesting the win melody (id 3).
REQ-006 Port req_lose, input, 1, one-cycle pulse requesting the lose melody (id 2).
REQ-007 Port req_p1, input, 1, one-cycle pulse requesting the player-1 pull chirp (id 1).
REQ-008 Port req_p2, input, 1, one-cycle pulse requesting the player-2 pull chirp (id 0).
REQ-009 Port mute, input, 1, forces spk low while sequencing continues unchanged.
REQ-010 Port spk, output, 1, square-wave speaker drive.
REQ-011 Port busy, output, 1, high in any state other than IDLE.
REQ-012 Port cur_id, output, 2, id of the melody loaded or playing; 0 when idle.
REQ-013 Port done, output, 1, one-cycle pulse when a melody completes all notes; no pulse on preemption.

Function
REQ-014 Each request pulse SHALL set a pending bit at the next edge; the bit clears when that id enters LOAD.
REQ-015 Priority SHALL be fixed: win > lose > p1 > p2. Simultaneous requests set all pending bits, and they are served in priority order.
REQ-016 States SHALL be IDLE, LOAD, PLAY, GAP.
- IDLE -> LOAD when any pending bit is set.
- LOAD (1 cycle) selects the highest pending id, sets note_idx=0, and drives spk=0.
- LOAD -> PLAY.
REQ-017 On entry to PLAY, spk SHALL go to 1 (unless mute or a rest note). The half-period counter loads HALF[id][note_idx]-1 and toggles spk each time it reaches 0, giving a period of 2*HALF cycles.
REQ-018 The note timer SHALL run NOTE_CYC cycles in PLAY. At expiry:
- if note_idx==3, pulse done and go to IDLE, or to LOAD if something is pending;
- otherwise go to GAP.
REQ-019 GAP SHALL hold spk=0 for GAP_CYC cycles, then increment note_idx and go to PLAY.
REQ-020 HALF value 0 SHALL denote a rest: spk is held 0 for that note's full duration.
REQ-021 In PLAY or GAP, a pending bit of strictly higher priority than cur_id SHALL cause a transition to LOAD on the next edge, aborting the current melody.
REQ-022 A request for the id currently playing SHALL be dropped, with no replay. Lower-priority requests stay pending.
REQ-023 On entry to LOAD with id 3 or 2, pending bits for ids 1 and 0 SHALL be cleared, because game over discards chirps.
REQ-024 Half-period values SHALL be 15-bit unsigned. The note timer SHALL be 24-bit. Both counters count down without wrap; reload happens only at 0.
REQ-025 spk SHALL equal tone_out AND NOT mute, and SHALL be 0 in IDLE, LOAD and GAP.

Reset
REQ-026 rst SHALL force the following immediately, including mid-melody:
- state IDLE;
- all pending bits, counters and note_idx to 0;
- spk=0, busy=0, cur_id=0, done=0.
REQ-027 After rst deasserts, the first request pulse SHALL be serviced normally. No request is remembered across reset.

Structure
REQ-028 Package sound_pkg SHALL hold:
- the state encoding;
- the melody id constants (P2=0, P1=1, LOSE=2, WIN=3);
- the 4x4 HALF table: win {11364,9019,7584,5682}, lose {7584,9019,11364,15169}, p1 {5682,0,0,0}, p2 {7584,0,0,0}.
REQ-029 One sub-module, tone_gen, SHALL hold the half-period counter and the toggle flop. Its inputs are clk, rst, start, half, and its output is tone_out. The sequencer holds the FSM, pending register, note timer and table lookup.

Verification
Benches SHALL use NOTE_CYC=20 and GAP_CYC=4.
REQ-030 Single req_p1 pulse at edge N:
- LOAD at N+1, PLAY at N+2, spk=1 at N+2;
- spk period 11364 cycles is truncated by the 20-cycle note, so spk stays 1;
- notes 1-3 are rests;
- done pulses after 4*20+3*4 cycles in PLAY/GAP;
- busy then falls.
REQ-031 req_p2 and req_win in the same cycle: win plays first (cur_id=3), p2 is discarded per REQ-023, and only one done pulse occurs.
REQ-032 req_lose during note 1 of p2: LOAD on the next edge, cur_id=2, no done pulse for p2, and the lose melody runs to done.
REQ-033 req_p2 during win playback: ignored and not pending. req_win repeated during win playback: dropped, with exactly one done.
REQ-034 mute=1 throughout a lose melody: spk stays constantly 0, while busy, cur_id, timing and done are identical to the unmuted run.
REQ-035 rst asserted mid-PLAY of the win melody: spk, busy, cur_id and the pending bits are 0 immediately. A req_p1 after release plays from note 0.
